// File: rtl/seg7_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan controller.
package seg7_pkg;

    localparam int CODE_W   = 5;
    localparam int MAX_CODE = 20;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_e;

    // A digit is bad if its stored parity disagrees or its code has no glyph.
    function automatic logic digit_err(input logic [CODE_W-1:0] code, input logic par);
        return (^code ^ par) | (code > CODE_W'(MAX_CODE));
    endfunction

endpackage

// File: rtl/seg7_phase_timer.sv
// Loadable down-counter timing the BLANK and SHOW phases; tc_o flags the last cycle.
module seg7_phase_timer
    import seg7_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Double-buffered digit scanner that time-shares one seven-segment decoder
// between NUM_DIGITS digits, with a blanking gap before every digit.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 1000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic                         load_valid_i,
    output logic                         load_ready_o,
    input  logic [CODE_W*NUM_DIGITS-1:0] load_code_i,
    input  logic [NUM_DIGITS-1:0]        load_par_i,
    output logic [CODE_W-1:0]            dec_code_o,
    output logic                         dec_parity_o,
    output logic [NUM_DIGITS-1:0]        digit_en_o,
    output logic [NUM_DIGITS-1:0]        err_flags_o,
    output logic                         frame_done_o
);

    localparam int MAX_CYC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_e                        state_q;
    logic [IDX_W-1:0]              idx_q;
    logic                          pending_q;
    logic                          have_data_q;
    logic [CODE_W*NUM_DIGITS-1:0]  shd_code_q;
    logic [NUM_DIGITS-1:0]         shd_par_q;
    logic [CODE_W*NUM_DIGITS-1:0]  act_code_q;
    logic [NUM_DIGITS-1:0]         act_par_q;
    logic [CODE_W-1:0]             dec_code_q;
    logic                          dec_parity_q;
    logic [NUM_DIGITS-1:0]         digit_en_q;
    logic [NUM_DIGITS-1:0]         err_q;
    logic                          frame_done_q;

    logic                          tc;
    logic                          show_end;
    logic                          last_digit;
    logic                          start_scan;
    logic                          enter_blank;
    logic                          swap_d;
    logic                          take_d;
    logic                          tmr_load_d;
    logic [CNT_W-1:0]              tmr_val_d;
    logic [IDX_W-1:0]              idx_d;
    logic [CODE_W*NUM_DIGITS-1:0]  src_code_d;
    logic [NUM_DIGITS-1:0]         src_par_d;
    logic [NUM_DIGITS-1:0]         err_d;
    logic [CODE_W-1:0]             sel_code_d;
    logic                          sel_par_d;
    logic                          sel_perr_d;
    logic                          sel_err_d;

    seg7_phase_timer #(.W(CNT_W)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load_d),
        .load_val_i (tmr_val_d),
        .tc_o       (tc)
    );

    // A swapping cycle reads the digit to display straight from the shadow
    // buffer, so the first digit of a new frame needs no extra cycle.
    always_comb begin
        show_end    = (state_q == SHOW) && tc;
        last_digit  = (idx_q == LAST_IDX);
        start_scan  = (state_q == IDLE) && enable_i && (pending_q || have_data_q);
        enter_blank = start_scan || (show_end && enable_i);
        swap_d      = pending_q && (((state_q == IDLE) && enable_i) || (show_end && last_digit));
        take_d      = load_valid_i && !pending_q;
        idx_d       = ((state_q == SHOW) && !last_digit && enable_i) ? idx_q + 1'b1 : '0;
        tmr_load_d  = enter_blank || ((state_q == BLANK) && tc);
        tmr_val_d   = (state_q == BLANK) ? CNT_W'(DIV - 1) : CNT_W'(BLANK_CYC - 1);
        src_code_d  = swap_d ? shd_code_q : act_code_q;
        src_par_d   = swap_d ? shd_par_q : act_par_q;
        sel_code_d  = src_code_d[CODE_W*int'(idx_d) +: CODE_W];
        sel_par_d   = src_par_d[idx_d];
        sel_perr_d  = ^sel_code_d ^ sel_par_d;
        sel_err_d   = digit_err(sel_code_d, sel_par_d);
        err_d       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            err_d[i] = digit_err(shd_code_q[CODE_W*i +: CODE_W], shd_par_q[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            have_data_q  <= 1'b0;
            shd_code_q   <= '0;
            shd_par_q    <= '0;
            act_code_q   <= '0;
            act_par_q    <= '0;
            dec_code_q   <= '0;
            dec_parity_q <= 1'b0;
            digit_en_q   <= '0;
            err_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (take_d) begin
                shd_code_q <= load_code_i;
                shd_par_q  <= load_par_i;
                pending_q  <= 1'b1;
            end
            if (swap_d) begin
                act_code_q  <= shd_code_q;
                act_par_q   <= shd_par_q;
                pending_q   <= 1'b0;
                have_data_q <= 1'b1;
                err_q       <= err_d;
            end
            // Out-of-range codes with good parity are zeroed so the decoder
            // only ever sees codes it has glyphs for.
            if (enter_blank) begin
                dec_parity_q <= sel_err_d;
                dec_code_q   <= (sel_err_d && !sel_perr_d) ? '0 : sel_code_d;
            end
            case (state_q)
                IDLE: begin
                    if (start_scan) begin
                        state_q <= BLANK;
                        idx_q   <= '0;
                    end
                end
                BLANK: begin
                    if (tc) begin
                        state_q    <= SHOW;
                        digit_en_q <= NUM_DIGITS'(1) << idx_q;
                    end
                end
                SHOW: begin
                    if (tc) begin
                        digit_en_q   <= '0;
                        idx_q        <= idx_d;
                        frame_done_q <= last_digit;
                        state_q      <= enable_i ? BLANK : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load_ready_o = ~pending_q;
    assign dec_code_o   = dec_code_q;
    assign dec_parity_o = dec_parity_q;
    assign digit_en_o   = digit_en_q;
    assign err_flags_o  = err_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, DIV=4, BLANK_CYC=1.
module tb_seg7_scan_ctrl;

    localparam int N      = 4;
    localparam int DIVC   = 4;
    localparam int BLANKC = 1;

    // Frame A {3,7,12,20}, good parity; B all 1s; C has a parity error on
    // digit 1 (code 5, par 1) and an out-of-range code 25 on digit 2; D all 2s.
    localparam logic [19:0] FRAME_A = {5'd20, 5'd12, 5'd7, 5'd3};
    localparam logic [3:0]  PAR_A   = 4'b0010;
    localparam logic [19:0] FRAME_B = {5'd1, 5'd1, 5'd1, 5'd1};
    localparam logic [3:0]  PAR_B   = 4'b1111;
    localparam logic [19:0] FRAME_C = {5'd20, 5'd25, 5'd5, 5'd3};
    localparam logic [3:0]  PAR_C   = 4'b0110;
    localparam logic [19:0] DEC_C   = {5'd20, 5'd0, 5'd5, 5'd3};
    localparam logic [3:0]  DPAR_C  = 4'b0110;
    localparam logic [19:0] FRAME_D = {5'd2, 5'd2, 5'd2, 5'd2};
    localparam logic [3:0]  PAR_D   = 4'b1111;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        loadValid;
    logic        loadReady;
    logic [19:0] loadCode;
    logic [3:0]  loadPar;
    logic [4:0]  decCode;
    logic        decParity;
    logic [3:0]  digitEn;
    logic [3:0]  errFlags;
    logic        frameDone;

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS (N),
        .DIV        (DIVC),
        .BLANK_CYC  (BLANKC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .load_valid_i (loadValid),
        .load_ready_o (loadReady),
        .load_code_i  (loadCode),
        .load_par_i   (loadPar),
        .dec_code_o   (decCode),
        .dec_parity_o (decParity),
        .digit_en_o   (digitEn),
        .err_flags_o  (errFlags),
        .frame_done_o (frameDone)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [19:0] code, input logic [3:0] par);
        loadValid = valid;
        loadCode  = code;
        loadPar   = par;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_en"}, 32'(digitEn), 0);
        checkOutput({tag, "_code"}, 32'(decCode), 0);
        checkOutput({tag, "_par"}, 32'(decParity), 0);
        checkOutput({tag, "_ready"}, 32'(loadReady), 1);
        checkOutput({tag, "_err"}, 32'(errFlags), 0);
        checkOutput({tag, "_fd"}, 32'(frameDone), 0);
    endtask

    // Entered on the blank sample of digit d; leaves on the next blank sample.
    task automatic scanDigit(input int d, input logic [4:0] eCode, input logic ePar,
                             input logic [3:0] eErr, input logic eFd);
        logic [3:0] oneHot;
        oneHot = 4'b0001 << d;
        checkOutput($sformatf("blank%0d_en", d), 32'(digitEn), 0);
        checkOutput($sformatf("blank%0d_code", d), 32'(decCode), 32'(eCode));
        checkOutput($sformatf("blank%0d_par", d), 32'(decParity), 32'(ePar));
        checkOutput($sformatf("blank%0d_fd", d), 32'(frameDone), 32'(eFd));
        checkOutput($sformatf("blank%0d_err", d), 32'(errFlags), 32'(eErr));
        for (int c = 0; c < DIVC; c++) begin
            @(negedge clk);
            checkOutput($sformatf("show%0d_en", d), 32'(digitEn), 32'(oneHot));
            checkOutput($sformatf("show%0d_code", d), 32'(decCode), 32'(eCode));
            checkOutput($sformatf("show%0d_par", d), 32'(decParity), 32'(ePar));
            checkOutput($sformatf("show%0d_fd", d), 32'(frameDone), 0);
        end
        @(negedge clk);
    endtask

    task automatic scanFrame(input logic [19:0] eCodes, input logic [3:0] ePars,
                             input logic [3:0] eErr, input logic fdFirst);
        for (int d = 0; d < N; d++) begin
            scanDigit(d, eCodes[5*d +: 5], ePars[d], eErr, (d == 0) ? fdFirst : 1'b0);
        end
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        applyStimulus(1'b0, '0, '0);
        #3;
        checkReset("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", 32'(loadReady), 1);
        checkOutput("idle_en", 32'(digitEn), 0);

        // Frame A while idle and enabled: digit 0 lights two edges after transfer.
        enable = 1'b1;
        applyStimulus(1'b1, FRAME_A, PAR_A);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0);
        checkOutput("xfer_ready", 32'(loadReady), 0);
        checkOutput("xfer_en", 32'(digitEn), 0);
        @(negedge clk);
        checkOutput("swap_ready", 32'(loadReady), 1);
        scanDigit(0, 5'd3, 1'b0, 4'b0000, 1'b0);

        // Frame B arrives during digit 1 and must wait for the frame boundary.
        applyStimulus(1'b1, FRAME_B, PAR_B);
        scanDigit(1, 5'd7, 1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b0, '0, '0);
        checkOutput("pend2_ready", 32'(loadReady), 0);
        scanDigit(2, 5'd12, 1'b0, 4'b0000, 1'b0);
        checkOutput("pend3_ready", 32'(loadReady), 0);
        scanDigit(3, 5'd20, 1'b0, 4'b0000, 1'b0);
        checkOutput("fd_ready", 32'(loadReady), 1);

        // Frame C offered during digit 0 of frame B.
        applyStimulus(1'b1, FRAME_C, PAR_C);
        scanDigit(0, 5'd1, 1'b0, 4'b0000, 1'b1);
        applyStimulus(1'b0, '0, '0);
        scanDigit(1, 5'd1, 1'b0, 4'b0000, 1'b0);
        scanDigit(2, 5'd1, 1'b0, 4'b0000, 1'b0);
        scanDigit(3, 5'd1, 1'b0, 4'b0000, 1'b0);

        // Frame C: parity error and out-of-range digits.
        scanDigit(0, 5'd3, 1'b0, 4'b0110, 1'b1);
        scanDigit(1, 5'd5, 1'b1, 4'b0110, 1'b0);
        checkOutput("blank2_en", 32'(digitEn), 0);
        checkOutput("blank2_code", 32'(decCode), 0);
        checkOutput("blank2_par", 32'(decParity), 1);
        @(negedge clk);
        checkOutput("drop_show1", 32'(digitEn), 32'(4'b0100));
        @(negedge clk);
        checkOutput("drop_show2", 32'(digitEn), 32'(4'b0100));
        enable = 1'b0;
        @(negedge clk);
        checkOutput("drop_show3", 32'(digitEn), 32'(4'b0100));
        @(negedge clk);
        checkOutput("drop_show4", 32'(digitEn), 32'(4'b0100));
        checkOutput("drop_show4_code", 32'(decCode), 0);
        checkOutput("drop_show4_par", 32'(decParity), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("idle_off_en", 32'(digitEn), 0);
            checkOutput("idle_off_fd", 32'(frameDone), 0);
        end

        // Re-enable restarts the scan at digit 0 of the active frame.
        enable = 1'b1;
        @(negedge clk);
        scanFrame(DEC_C, DPAR_C, 4'b0110, 1'b0);
        checkOutput("loop_fd", 32'(frameDone), 1);

        // Load D, then reset mid-SHOW while it is still pending.
        applyStimulus(1'b1, FRAME_D, PAR_D);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0);
        checkOutput("d_pend_ready", 32'(loadReady), 0);
        checkOutput("d_show_en", 32'(digitEn), 32'(4'b0001));
        #2;
        rst = 1'b1;
        #1;
        checkReset("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("postrst_en", 32'(digitEn), 0);
            checkOutput("postrst_ready", 32'(loadReady), 1);
        end

        // A fresh load after reset displays normally.
        applyStimulus(1'b1, FRAME_A, PAR_A);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0);
        checkOutput("reload_en", 32'(digitEn), 0);
        @(negedge clk);
        scanFrame(FRAME_A, 4'b0000, 4'b0000, 1'b0);
        checkOutput("final_fd", 32'(frameDone), 1);
        checkOutput("final_code", 32'(decCode), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
